// File: rtl/radiant_trig_cfg_seq.sv
// Wishbone-master sequencer that atomically reprograms one RADIANT trigger:
// save master enable, disable core, write mask/window/threshold/enable, restore.
module radiant_trig_cfg_seq #(
  parameter int unsigned NUM_TRIG      = 4,
  parameter int unsigned NUM_CH        = 24,
  parameter int unsigned ONESHOT_WIDTH = 20,
  parameter int unsigned THRESH_WIDTH  = 5,
  parameter int unsigned ACK_TIMEOUT   = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_i,
  input  logic [3:0]               req_trig_i,
  input  logic                     req_en_i,
  input  logic [NUM_CH-1:0]        req_maskb_i,
  input  logic [ONESHOT_WIDTH-1:0] req_window_i,
  input  logic [THRESH_WIDTH-1:0]  req_thresh_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [8:0]               wbm_adr_o,
  output logic [31:0]              wbm_dat_o,
  output logic [3:0]               wbm_sel_o,
  input  logic [31:0]              wbm_dat_i,
  input  logic                     wbm_ack_i
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_MEN, S_WR_MDIS, S_WR_MASK, S_WR_WIN,
    S_WR_THR, S_WR_EN, S_WR_MRES, S_DONE
  } state_e;

  state_e state_q, state_d, ack_next, to_next;

  logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                     cyc_q, cyc_d, we_q, we_d;
  logic [8:0]               adr_q, adr_d;
  logic [31:0]              dat_q, dat_d;
  logic [3:0]               sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               trig_q, trig_d;
  logic                     en_q, en_d, men_q, men_d;
  logic [NUM_CH-1:0]        maskb_q, maskb_d;
  logic [ONESHOT_WIDTH-1:0] window_q, window_d;
  logic [THRESH_WIDTH-1:0]  thresh_q, thresh_d;

  logic                     acc_we;
  logic [8:0]               acc_adr, trig_base;
  logic [31:0]              acc_dat;
  logic [3:0]               acc_sel;
  logic                     req_bad;
  logic                     unused_dat;

  assign unused_dat = ^wbm_dat_i[31:1];
  assign req_bad    = ({1'b0, req_trig_i} >= 5'(NUM_TRIG));
  assign trig_base  = {1'b1, trig_q, 4'h0};

  // Bus access presented by each sequencing state
  always_comb begin
    acc_we  = 1'b1;
    acc_sel = 4'hF;
    acc_adr = 9'h000;
    acc_dat = 32'h0;
    case (state_q)
      S_RD_MEN:  acc_we = 1'b0;
      S_WR_MDIS: acc_sel = 4'h1;
      S_WR_MASK: begin acc_adr = trig_base | 9'h004; acc_dat = 32'(maskb_q);  end
      S_WR_WIN:  begin acc_adr = trig_base | 9'h008; acc_dat = 32'(window_q); end
      S_WR_THR:  begin acc_adr = trig_base | 9'h00C; acc_dat = 32'(thresh_q); end
      S_WR_EN:   begin acc_adr = trig_base;          acc_dat = {en_q, 31'h0}; end
      S_WR_MRES: begin acc_sel = 4'h1;               acc_dat = {31'h0, men_q}; end
      default: ;
    endcase
  end

  // Successor on ack and on timeout; a timeout after disabling still restores
  always_comb begin
    ack_next = S_DONE;
    to_next  = S_WR_MRES;
    case (state_q)
      S_RD_MEN:  begin ack_next = S_WR_MDIS; to_next = S_DONE; end
      S_WR_MDIS: ack_next = S_WR_MASK;
      S_WR_MASK: ack_next = S_WR_WIN;
      S_WR_WIN:  ack_next = S_WR_THR;
      S_WR_THR:  ack_next = S_WR_EN;
      S_WR_EN:   ack_next = S_WR_MRES;
      S_WR_MRES: begin ack_next = S_DONE; to_next = S_DONE; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    trig_d   = trig_q;
    en_d     = en_q;
    men_d    = men_q;
    maskb_d  = maskb_q;
    window_d = window_q;
    thresh_d = thresh_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          trig_d   = req_trig_i;
          en_d     = req_en_i;
          maskb_d  = req_maskb_i;
          window_d = req_window_i;
          thresh_d = req_thresh_i;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          if (req_bad) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            // First access launches on acceptance so stb is up the next cycle
            state_d = S_RD_MEN;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = 9'h000;
            dat_d   = 32'h0;
            sel_d   = 4'hF;
            cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        if (done_q) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        // stb low here is the mandatory idle cycle; ack only counts with stb up
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = acc_we;
          adr_d = acc_adr;
          dat_d = acc_dat;
          sel_d = acc_sel;
          cnt_d = '0;
        end else if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          state_d = ack_next;
          if (state_q == S_RD_MEN) men_d = wbm_dat_i[0];
        end else if (cnt_q == CNT_LAST) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = to_next;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 9'h000;
      dat_q    <= 32'h0;
      sel_q    <= 4'h0;
      cnt_q    <= '0;
      trig_q   <= 4'h0;
      en_q     <= 1'b0;
      men_q    <= 1'b0;
      maskb_q  <= '0;
      window_q <= '0;
      thresh_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      en_q     <= en_d;
      men_q    <= men_d;
      maskb_q  <= maskb_d;
      window_q <= window_d;
      thresh_q <= thresh_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_radiant_trig_cfg_seq.sv
// Scoreboard bench for radiant_trig_cfg_seq against a registered-ack trigger-core model.
module tb_radiant_trig_cfg_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_i;
  logic [3:0]  req_trig_i;
  logic        req_en_i;
  logic [23:0] req_maskb_i;
  logic [19:0] req_window_i;
  logic [4:0]  req_thresh_i;
  logic        busy_o, done_o, err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [8:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  radiant_trig_cfg_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .req_trig_i(req_trig_i),
    .req_en_i(req_en_i), .req_maskb_i(req_maskb_i), .req_window_i(req_window_i),
    .req_thresh_i(req_thresh_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc_n = 0;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Trigger core model: registered ack (with trailing ack), master enable, trigger regs
  logic        men = 1'b0;
  logic        ack_q = 1'b0;
  logic        force_men = 1'b0, force_val = 1'b0;
  logic        hold_en = 1'b0;
  logic [8:0]  hold_adr = 9'h0;
  logic [31:0] m_mask [16];
  logic [31:0] m_win  [16];
  logic [31:0] m_thr  [16];
  logic        m_ten  [16];
  int          viol = 0;

  assign wbm_ack_i = ack_q;
  assign wbm_dat_i = (wbm_adr_o == 9'h000) ? {31'h0, men} : 32'h0;

  always @(posedge clk_i) begin
    ack_q <= wbm_cyc_o && wbm_stb_o && !(hold_en && wbm_adr_o == hold_adr);
    if (force_men) men <= force_val;
    else if (wbm_cyc_o && wbm_stb_o && ack_q && wbm_we_o) begin
      if (wbm_adr_o == 9'h000) begin
        if (wbm_sel_o[0]) men <= wbm_dat_o[0];
      end else if (wbm_adr_o[8]) begin
        if (men) viol <= viol + 1;
        case (wbm_adr_o[3:0])
          4'h0: m_ten[wbm_adr_o[7:4]]  <= wbm_dat_o[31];
          4'h4: m_mask[wbm_adr_o[7:4]] <= wbm_dat_o;
          4'h8: m_win[wbm_adr_o[7:4]]  <= wbm_dat_o;
          4'hC: m_thr[wbm_adr_o[7:4]]  <= wbm_dat_o;
          default: ;
        endcase
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [8:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } acc_t;

  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];

  // Monitor: every completed handshake and every done pulse is popped and compared
  int run = 0, to_runs = 0, last_to_run = 0;
  bit run_ack = 0;
  always @(negedge clk_i) begin
    acc_t  a;
    acc_t  e;
    done_t d;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      a = '{we: wbm_we_o, adr: wbm_adr_o, sel: wbm_sel_o, dat: (wbm_we_o ? wbm_dat_o : 32'h0)};
      if (exp_acc.size() == 0) chk("unexpected_access", 64'(a), 64'h0);
      else begin
        e = exp_acc.pop_front();
        chk("bus_access", 64'(a), 64'(e));
      end
    end
    if (done_o) begin
      if (exp_done.size() == 0) chk("unexpected_done", 64'(cyc_n), 64'h0);
      else begin
        d = exp_done.pop_front();
        chk("done_cycle", 64'(cyc_n), 64'(d.cyc));
        chk("done_err", 64'(err_o), 64'(d.err));
      end
    end
    if (wbm_stb_o) begin
      run++;
      if (wbm_ack_i) run_ack = 1;
    end else begin
      if (run > 0 && !run_ack) begin
        to_runs++;
        last_to_run = run;
      end
      run = 0;
      run_ack = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic set_men(input logic v);
    force_val = v;
    force_men = 1'b1;
    step(1);
    force_men = 1'b0;
  endtask

  task automatic issue(input logic [3:0] t, input logic en, input logic [23:0] m,
                       input logic [19:0] w, input logic [4:0] th, output int c);
    req_trig_i = t; req_en_i = en; req_maskb_i = m; req_window_i = w; req_thresh_i = th;
    req_i = 1'b1;
    c = cyc_n;
  endtask

  // Full nominal sequence accepted at the end of cycle c0
  task automatic push_op(input logic [3:0] t, input logic en, input logic [23:0] m,
                         input logic [19:0] w, input logic [4:0] th, input logic ms,
                         input int c0);
    logic [8:0] b;
    done_t d;
    b = 9'(12'h100 + 16 * int'(t));
    exp_acc.push_back('{we: 1'b0, adr: 9'h000, sel: 4'hF, dat: 32'h0});
    exp_acc.push_back('{we: 1'b1, adr: 9'h000, sel: 4'h1, dat: 32'h0});
    exp_acc.push_back('{we: 1'b1, adr: b + 9'h4, sel: 4'hF, dat: {8'h0, m}});
    exp_acc.push_back('{we: 1'b1, adr: b + 9'h8, sel: 4'hF, dat: {12'h0, w}});
    exp_acc.push_back('{we: 1'b1, adr: b + 9'hC, sel: 4'hF, dat: {27'h0, th}});
    exp_acc.push_back('{we: 1'b1, adr: b, sel: 4'hF, dat: {en, 31'h0}});
    exp_acc.push_back('{we: 1'b1, adr: 9'h000, sel: 4'h1, dat: {31'h0, ms}});
    d.cyc = c0 + 22;
    d.err = 1'b0;
    exp_done.push_back(d);
  endtask

  initial begin
    int    c, to0;
    done_t d;
    rst_n_i = 1'b0; req_i = 1'b0; req_trig_i = 4'h0; req_en_i = 1'b0;
    req_maskb_i = '0; req_window_i = '0; req_thresh_i = '0;
    step(3);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_done", 64'(done_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_bus_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'h0);
    chk("rst_bus_data", 64'({wbm_adr_o, wbm_dat_o, wbm_sel_o}), 64'h0);
    rst_n_i = 1'b1;
    step(2);

    // Nominal, master enable on, trigger 2
    set_men(1'b1);
    issue(4'd2, 1'b1, 24'h00F00F, 20'h0A5A5, 5'd7, c);
    push_op(4'd2, 1'b1, 24'h00F00F, 20'h0A5A5, 5'd7, 1'b1, c);
    step(1);
    req_i = 1'b0;
    chk("nom_busy_rise", 64'(busy_o), 64'h1);
    chk("nom_first_stb", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'h6);
    step(22);
    chk("nom_busy_fall", 64'(busy_o), 64'h0);
    chk("nom_err", 64'(err_o), 64'h0);
    chk("nom_men", 64'(men), 64'h1);
    chk("nom_mask2", 64'(m_mask[2]), 64'h00F00F);
    chk("nom_win2", 64'(m_win[2]), 64'h0A5A5);
    chk("nom_thr2", 64'(m_thr[2]), 64'h7);
    chk("nom_en2", 64'(m_ten[2]), 64'h1);

    // Master enable initially off: restore writes 0, trigger stays inactive
    set_men(1'b0);
    issue(4'd2, 1'b1, 24'h123456, 20'h54321, 5'h1F, c);
    push_op(4'd2, 1'b1, 24'h123456, 20'h54321, 5'h1F, 1'b0, c);
    step(1);
    req_i = 1'b0;
    step(23);
    chk("men0_men", 64'(men), 64'h0);
    chk("men0_eff_en2", 64'(men & m_ten[2]), 64'h0);
    chk("men0_thr2", 64'(m_thr[2]), 64'h1F);

    // Invalid trigger index: no bus cycle, immediate done with error
    issue(4'd5, 1'b1, 24'hFFFFFF, 20'h1, 5'd1, c);
    d.cyc = c + 1;
    d.err = 1'b1;
    exp_done.push_back(d);
    step(1);
    req_i = 1'b0;
    chk("inv_cyc", 64'(wbm_cyc_o), 64'h0);
    chk("inv_err", 64'(err_o), 64'h1);
    step(1);
    chk("inv_idle", 64'({busy_o, done_o, wbm_cyc_o}), 64'h0);
    chk("inv_err_sticky", 64'(err_o), 64'h1);

    // Ack withheld in WR_WIN: timeout, then only the restore write
    set_men(1'b1);
    hold_en = 1'b1;
    hold_adr = 9'h108;
    to0 = to_runs;
    issue(4'd0, 1'b1, 24'h000001, 20'h00002, 5'd3, c);
    exp_acc.push_back('{we: 1'b0, adr: 9'h000, sel: 4'hF, dat: 32'h0});
    exp_acc.push_back('{we: 1'b1, adr: 9'h000, sel: 4'h1, dat: 32'h0});
    exp_acc.push_back('{we: 1'b1, adr: 9'h104, sel: 4'hF, dat: 32'h1});
    exp_acc.push_back('{we: 1'b1, adr: 9'h000, sel: 4'h1, dat: 32'h1});
    d.cyc = c + 29;
    d.err = 1'b1;
    exp_done.push_back(d);
    step(1);
    req_i = 1'b0;
    chk("to_err_cleared", 64'(err_o), 64'h0);
    step(30);
    hold_en = 1'b0;
    chk("to_runs", 64'(to_runs - to0), 64'h1);
    chk("to_stb_len", 64'(last_to_run), 64'd15);
    chk("to_err", 64'(err_o), 64'h1);
    chk("to_busy", 64'(busy_o), 64'h0);
    chk("to_men_restored", 64'(men), 64'h1);

    // req_i held, data changed mid-operation: second accepted only after done
    issue(4'd1, 1'b1, 24'hAAAAAA, 20'h11111, 5'd3, c);
    push_op(4'd1, 1'b1, 24'hAAAAAA, 20'h11111, 5'd3, 1'b1, c);
    push_op(4'd1, 1'b0, 24'h555555, 20'h22222, 5'd9, 1'b1, c + 23);
    step(10);
    req_en_i = 1'b0; req_maskb_i = 24'h555555; req_window_i = 20'h22222; req_thresh_i = 5'd9;
    chk("hold_busy_mid", 64'(busy_o), 64'h1);
    step(14);
    req_i = 1'b0;
    step(22);
    chk("hold_busy", 64'(busy_o), 64'h0);
    chk("hold_mask1", 64'(m_mask[1]), 64'h555555);
    chk("hold_thr1", 64'(m_thr[1]), 64'h9);
    chk("hold_en1", 64'(m_ten[1]), 64'h0);

    // Reset during WR_THR, then a fresh request completes with master left off
    set_men(1'b1);
    issue(4'd3, 1'b1, 24'h0F0F0F, 20'h00100, 5'd2, c);
    exp_acc.push_back('{we: 1'b0, adr: 9'h000, sel: 4'hF, dat: 32'h0});
    exp_acc.push_back('{we: 1'b1, adr: 9'h000, sel: 4'h1, dat: 32'h0});
    exp_acc.push_back('{we: 1'b1, adr: 9'h134, sel: 4'hF, dat: 32'h0F0F0F});
    exp_acc.push_back('{we: 1'b1, adr: 9'h138, sel: 4'hF, dat: 32'h00100});
    step(1);
    req_i = 1'b0;
    step(12);
    chk("rst_mid_thr_stb", 64'({wbm_stb_o, wbm_adr_o}), 64'({1'b1, 9'h13C}));
    rst_n_i = 1'b0;
    step(1);
    chk("rst_mid_bus", 64'({wbm_cyc_o, wbm_stb_o}), 64'h0);
    chk("rst_mid_busy", 64'(busy_o), 64'h0);
    rst_n_i = 1'b1;
    step(2);
    chk("rst_mid_men_off", 64'(men), 64'h0);
    issue(4'd3, 1'b1, 24'hFFFFFF, 20'hFFFFF, 5'h1F, c);
    push_op(4'd3, 1'b1, 24'hFFFFFF, 20'hFFFFF, 5'h1F, 1'b0, c);
    step(1);
    req_i = 1'b0;
    step(23);
    chk("fresh_busy", 64'(busy_o), 64'h0);
    chk("fresh_err", 64'(err_o), 64'h0);
    chk("fresh_mask3", 64'(m_mask[3]), 64'hFFFFFF);
    chk("fresh_win3", 64'(m_win[3]), 64'hFFFFF);

    step(5);
    chk("acc_queue_empty", 64'(exp_acc.size()), 64'h0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'h0);
    chk("cfg_rule_violations", 64'(viol), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
